// File: rtl/vx_popcount_pipe.sv
// Pipelined, back-pressured population count of an N-bit word with a saturating
// running total per group of beats delimited by last_in.
module vx_popcount_pipe #(
    parameter int N       = 32,
    parameter int CHUNK   = 6,
    parameter int LATENCY = 2,
    parameter int ACC_W   = 16,
    parameter int M       = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [N-1:0]     data_in,
    input  logic             invert_in,
    input  logic             last_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [M-1:0]     count_out,
    output logic [ACC_W-1:0] total_out,
    output logic             last_out,
    output logic             overflow_out
);
    localparam int NC  = (N + CHUNK - 1) / CHUNK;
    localparam int NP  = (NC + 1) / 2;
    localparam int NCP = 2 * NP;
    localparam int CW  = $clog2(CHUNK + 1);
    localparam int AW1 = ACC_W + 1;
    localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

    logic             valid_out_q, valid_out_d;
    logic [M-1:0]     count_q, count_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             grp_start_q, grp_start_d;

    logic                 en;
    logic [NCP*CHUNK-1:0] dp;
    logic [CW-1:0]        cc_d [NCP];
    logic [M-1:0]         cnt_pre;
    logic                 v_pre;
    logic                 last_pre;
    logic [ACC_W:0]       acc_sum;
    logic                 acc_sat;

    assign en       = !valid_out_q || ready_out;
    assign ready_in = en;

    // Chunk count padded to an even number so the pair stage never indexes past the end;
    // padding chunks and padding bits are constant zero.
    always_comb begin
        dp        = '0;
        dp[N-1:0] = invert_in ? ~data_in : data_in;
        for (int unsigned i = 0; i < NCP; i++) begin
            cc_d[i] = '0;
            for (int unsigned b = 0; b < CHUNK; b++) begin
                cc_d[i] = cc_d[i] + CW'(dp[i*CHUNK + b]);
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            always_comb begin
                cnt_pre = '0;
                for (int unsigned i = 0; i < NCP; i++) begin
                    cnt_pre = cnt_pre + M'(cc_d[i]);
                end
                v_pre    = valid_in;
                last_pre = last_in;
            end
        end else begin : g_lat23
            logic [CW-1:0] cc_q [NCP];
            logic          s1_valid_q;
            logic          s1_last_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cc_q       <= '{default: '0};
                    s1_valid_q <= 1'b0;
                    s1_last_q  <= 1'b0;
                end else if (en) begin
                    cc_q       <= cc_d;
                    s1_valid_q <= valid_in;
                    s1_last_q  <= last_in;
                end
            end

            if (LATENCY == 2) begin : g_lat2
                always_comb begin
                    cnt_pre = '0;
                    for (int unsigned i = 0; i < NCP; i++) begin
                        cnt_pre = cnt_pre + M'(cc_q[i]);
                    end
                    v_pre    = s1_valid_q;
                    last_pre = s1_last_q;
                end
            end else begin : g_lat3
                logic [M-1:0] ps_d [NP];
                logic [M-1:0] ps_q [NP];
                logic         s2_valid_q;
                logic         s2_last_q;

                always_comb begin
                    for (int unsigned j = 0; j < NP; j++) begin
                        ps_d[j] = M'(cc_q[2*j]) + M'(cc_q[2*j + 1]);
                    end
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        ps_q       <= '{default: '0};
                        s2_valid_q <= 1'b0;
                        s2_last_q  <= 1'b0;
                    end else if (en) begin
                        ps_q       <= ps_d;
                        s2_valid_q <= s1_valid_q;
                        s2_last_q  <= s1_last_q;
                    end
                end

                always_comb begin
                    cnt_pre = '0;
                    for (int unsigned j = 0; j < NP; j++) begin
                        cnt_pre = cnt_pre + ps_q[j];
                    end
                    v_pre    = s2_valid_q;
                    last_pre = s2_last_q;
                end
            end
        end
    endgenerate

    // Output register and accumulator change only when a real beat loads; bubbles hold them.
    always_comb begin
        valid_out_d = en ? v_pre : valid_out_q;
        count_d     = count_q;
        total_d     = total_q;
        last_d      = last_q;
        ovf_d       = ovf_q;
        grp_start_d = grp_start_q;
        acc_sum     = (grp_start_q ? '0 : {1'b0, total_q}) + AW1'(cnt_pre);
        acc_sat     = acc_sum > ACC_MAX;
        if (en && v_pre) begin
            count_d     = cnt_pre;
            total_d     = acc_sat ? '1 : acc_sum[ACC_W-1:0];
            ovf_d       = (grp_start_q ? 1'b0 : ovf_q) | acc_sat;
            last_d      = last_pre;
            grp_start_d = last_pre;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            count_q     <= '0;
            total_q     <= '0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
            grp_start_q <= 1'b1;
        end else begin
            valid_out_q <= valid_out_d;
            count_q     <= count_d;
            total_q     <= total_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            grp_start_q <= grp_start_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign count_out    = count_q;
    assign total_out    = total_q;
    assign last_out     = last_q;
    assign overflow_out = ovf_q;

endmodule

// File: tb/tb_vx_popcount_pipe.sv
// Scoreboard bench for vx_popcount_pipe: three instances (default, N=33/LATENCY=3/ACC_W=6,
// LATENCY=1) receive the same beats; each has its own reference model and expectation queue.
module tb_vx_popcount_pipe;
    typedef struct packed {
        logic [5:0]  cnt;
        logic [15:0] tot;
        logic        lst;
        logic        ovf;
    } beat_t;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [2:0]  pend      = 3'b000;
    logic [31:0] data_in   = '0;
    logic        invert_in = 1'b0;
    logic        last_in   = 1'b0;
    logic        ready_out = 1'b1;

    logic [32:0] data_b;
    logic [2:0]  rdy, vo, lst, ovf;
    logic [5:0]  cnt_a, cnt_b, cnt_c;
    logic [15:0] tot_a, tot_c;
    logic [5:0]  tot_b;
    beat_t       obs [3];

    int checks = 0;
    int errors = 0;

    int unsigned m_tot [3];
    bit          m_grp [3];
    bit          m_ovf [3];
    beat_t       sb0[$], sb1[$], sb2[$];

    assign data_b = {1'b0, data_in};
    assign obs[0] = {cnt_a, tot_a, lst[0], ovf[0]};
    assign obs[1] = {cnt_b, 10'd0, tot_b, lst[1], ovf[1]};
    assign obs[2] = {cnt_c, tot_c, lst[2], ovf[2]};

    always #5 clk = ~clk;

    vx_popcount_pipe #(.N(32), .CHUNK(6), .LATENCY(2), .ACC_W(16)) dut_a (
        .clk(clk), .reset(reset), .valid_in(pend[0]), .ready_in(rdy[0]),
        .data_in(data_in), .invert_in(invert_in), .last_in(last_in),
        .valid_out(vo[0]), .ready_out(ready_out), .count_out(cnt_a),
        .total_out(tot_a), .last_out(lst[0]), .overflow_out(ovf[0])
    );

    vx_popcount_pipe #(.N(33), .CHUNK(6), .LATENCY(3), .ACC_W(6)) dut_b (
        .clk(clk), .reset(reset), .valid_in(pend[1]), .ready_in(rdy[1]),
        .data_in(data_b), .invert_in(invert_in), .last_in(last_in),
        .valid_out(vo[1]), .ready_out(ready_out), .count_out(cnt_b),
        .total_out(tot_b), .last_out(lst[1]), .overflow_out(ovf[1])
    );

    vx_popcount_pipe #(.N(32), .CHUNK(6), .LATENCY(1), .ACC_W(16)) dut_c (
        .clk(clk), .reset(reset), .valid_in(pend[2]), .ready_in(rdy[2]),
        .data_in(data_in), .invert_in(invert_in), .last_in(last_in),
        .valid_out(vo[2]), .ready_out(ready_out), .count_out(cnt_c),
        .total_out(tot_c), .last_out(lst[2]), .overflow_out(ovf[2])
    );

    function automatic int unsigned acc_max(int k);
        return (k == 1) ? 32'd63 : 32'd65535;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_tot[k] = 0;
            m_grp[k] = 1'b1;
            m_ovf[k] = 1'b0;
        end
        sb0.delete();
        sb1.delete();
        sb2.delete();
    endfunction

    function automatic void sb_push(int k, beat_t e);
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endfunction

    function automatic int sb_size(int k);
        case (k)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic beat_t sb_pop(int k);
        beat_t e;
        case (k)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
        return e;
    endfunction

    // One clock: sample mid-cycle, record accepted beats, pop and compare delivered beats.
    task automatic tick();
        beat_t       e;
        logic [32:0] w;
        int unsigned c, s;
        bit          sat;
        logic [2:0]  taken;
        taken = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (pend[k] && rdy[k]) begin
                w = {1'b0, data_in};
                if (invert_in) w = ~w;
                if (k != 1) w[32] = 1'b0;
                c        = $countones(w);
                s        = (m_grp[k] ? 0 : m_tot[k]) + c;
                sat      = s > acc_max(k);
                m_ovf[k] = (m_grp[k] ? 1'b0 : m_ovf[k]) | sat;
                m_tot[k] = sat ? acc_max(k) : s;
                m_grp[k] = last_in;
                e.cnt    = 6'(c);
                e.tot    = 16'(m_tot[k]);
                e.lst    = last_in;
                e.ovf    = m_ovf[k];
                sb_push(k, e);
                taken[k] = 1'b1;
            end
            if (vo[k] && ready_out) begin
                checks++;
                if (sb_size(k) == 0) begin
                    errors++;
                    $display("FAIL sb_dut%0d unexpected beat cnt=%0d tot=%0d, required no beat",
                             k, obs[k].cnt, obs[k].tot);
                end else begin
                    e = sb_pop(k);
                    if (obs[k] !== e) begin
                        errors++;
                        $display("FAIL sb_dut%0d got cnt=%0d tot=%0d last=%0b ovf=%0b required cnt=%0d tot=%0d last=%0b ovf=%0b",
                                 k, obs[k].cnt, obs[k].tot, obs[k].lst, obs[k].ovf,
                                 e.cnt, e.tot, e.lst, e.ovf);
                    end
                end
            end
        end
        @(negedge clk);
        pend = pend & ~taken;
    endtask

    task automatic send(input logic [31:0] d, input logic inv, input logic lst_i);
        data_in   = d;
        invert_in = inv;
        last_in   = lst_i;
        pend      = 3'b111;
        for (int n = 0; n < 40 && pend != 3'b000; n++) tick();
        checks++;
        if (pend !== 3'b000) begin
            errors++;
            $display("FAIL send_timeout pending=%b required=000", pend);
            pend = 3'b000;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && (sb0.size() + sb1.size() + sb2.size()) != 0; n++) tick();
        checks++;
        if ((sb0.size() + sb1.size() + sb2.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout outstanding=%0d/%0d/%0d required=0/0/0",
                     sb0.size(), sb1.size(), sb2.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vo[k] !== 1'b0 || obs[k] !== '0 || rdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_dut%0d valid=%b outs=%h ready_in=%b required valid=0 outs=0 ready_in=1",
                         k, vo[k], obs[k], rdy[k]);
            end
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        checks++;
        if (vo !== 3'b100) begin
            errors++;
            $display("FAIL latency_cycle1 valid_out=%b required=100", vo);
        end
        tick();
        checks++;
        if (vo[0] !== 1'b1 || vo[1] !== 1'b0 || cnt_a !== 6'd32 || tot_a !== 16'd32 || lst[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_word valid=%b/%b cnt=%0d tot=%0d last=%b required valid=1/0 cnt=32 tot=32 last=1",
                     vo[0], vo[1], cnt_a, tot_a, lst[0]);
        end
        drain();
    endtask

    task automatic test_stream();
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0001, 1'b0, 1'b1);
        send(32'h0000_0003, 1'b0, 1'b1);
        drain();
        checks++;
        if (cnt_a !== 6'd2 || tot_a !== 16'd2 || tot_b !== 6'd2 || tot_c !== 16'd2) begin
            errors++;
            $display("FAIL group_restart cnt=%0d tot=%0d/%0d/%0d required cnt=2 tot=2/2/2",
                     cnt_a, tot_a, tot_b, tot_c);
        end
    endtask

    task automatic test_invert();
        send(32'hF0F0_F0F0, 1'b1, 1'b1);
        send(32'h0000_0000, 1'b1, 1'b1);
        drain();
        checks++;
        if (cnt_a !== 6'd32 || tot_a !== 16'd32 || cnt_b !== 6'd33 || tot_b !== 6'd33) begin
            errors++;
            $display("FAIL invert_zero cnt=%0d/%0d tot=%0d/%0d required cnt=32/33 tot=32/33",
                     cnt_a, cnt_b, tot_a, tot_b);
        end
    endtask

    task automatic test_stall();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send($urandom, 1'($urandom_range(0, 1)), (i % 4 == 3) || (i == 9));
                end
            end
            begin
                repeat (3) @(negedge clk);
                ready_out = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    checks++;
                    if (rdy !== 3'b000 || vo !== 3'b111) begin
                        errors++;
                        $display("FAIL stall_cycle%0d ready_in=%b valid_out=%b required ready_in=000 valid_out=111",
                                 i, rdy, vo);
                    end
                    @(negedge clk);
                end
                ready_out = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_saturate();
        repeat (3) send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();
        checks++;
        if (tot_b !== 6'd63 || ovf[1] !== 1'b1 || lst[1] !== 1'b1 || tot_a !== 16'd128 || ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL saturate tot=%0d ovf=%b last=%b wide_tot=%0d wide_ovf=%b required 63 1 1 128 0",
                     tot_b, ovf[1], lst[1], tot_a, ovf[0]);
        end
        send(32'h0000_0001, 1'b0, 1'b1);
        drain();
        checks++;
        if (tot_b !== 6'd1 || ovf[1] !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear tot=%0d ovf=%b required tot=1 ovf=0", tot_b, ovf[1]);
        end
    endtask

    task automatic test_reset_midflight();
        send(32'hAAAA_AAAA, 1'b0, 1'b0);
        send(32'h5555_5555, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (vo !== 3'b000 || obs[0] !== '0 || obs[1] !== '0 || obs[2] !== '0) begin
            errors++;
            $display("FAIL midflight_reset valid_out=%b outs=%h/%h/%h required 000 and zero outputs",
                     vo, obs[0], obs[1], obs[2]);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (vo !== 3'b000) begin
            errors++;
            $display("FAIL after_reset valid_out=%b required=000", vo);
        end
        send(32'h00FF_00FF, 1'b0, 1'b0);
        drain();
        checks++;
        if (cnt_a !== 6'd16 || tot_a !== 16'd16 || tot_b !== 6'd16 || tot_c !== 16'd16) begin
            errors++;
            $display("FAIL fresh_group cnt=%0d tot=%0d/%0d/%0d required cnt=16 tot=16/16/16",
                     cnt_a, tot_a, tot_b, tot_c);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_word();
        test_stream();
        test_invert();
        test_stall();
        test_saturate();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
